// File: rtl/multi_button_debounce.sv
// rtl/multi_button_debounce.sv - N-channel push-button debouncer with level, press and release outputs
// Optional auto-repeat of btn_press on held buttons: define AUTOREPEAT_EN.
module multi_button_debounce #(
  parameter int NCH          = 5,
  parameter int TICK_DIV     = 100000,
  parameter int STABLE_TICKS = 10,
  parameter int HOLD_TICKS   = 500,
  parameter int REPEAT_TICKS = 100
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] btn_in,
  output logic [NCH-1:0] btn_level,
  output logic [NCH-1:0] btn_press,
  output logic [NCH-1:0] btn_release
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_TICKS - 1);

  // Refuse to elaborate with parameters the counters cannot represent.
  if (TICK_DIV < 2 || STABLE_TICKS < 1 || REPEAT_TICKS < 1 || REPEAT_TICKS > HOLD_TICKS) begin : g_bad_params
    $error("multi_button_debounce: illegal parameter combination");
  end

  logic [NCH-1:0] sync1_q;
  logic [NCH-1:0] sync2_q;
  logic [PW-1:0]  presc_q, presc_d;
  logic           tick;
  logic [CW-1:0]  cnt_q [NCH];
  logic [CW-1:0]  cnt_d [NCH];
  logic [NCH-1:0] level_q, level_d;
  logic [NCH-1:0] press_q, press_d;
  logic [NCH-1:0] rel_q, rel_d;

`ifdef AUTOREPEAT_EN
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_TICKS - 1);
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_TICKS - REPEAT_TICKS);
  logic [HW-1:0] hc_q [NCH];
  logic [HW-1:0] hc_d [NCH];
`endif

  // Shared sample-tick prescaler: tick marks the last cycle of each period.
  always_comb begin
    tick    = (presc_q == PRESC_LAST);
    presc_d = tick ? '0 : presc_q + 1'b1;
  end

  // Per-channel qualification: any match restarts the count, the
  // STABLE_TICKS-th consecutive mismatching tick accepts the new level.
  always_comb begin
    level_d = level_q;
    press_d = '0;
    rel_d   = '0;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick) begin
        if (cnt_q[i] == CNT_LAST) begin
          cnt_d[i]   = '0;
          level_d[i] = ~level_q[i];
          press_d[i] = ~level_q[i];
          rel_d[i]   = level_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
`ifdef AUTOREPEAT_EN
      // Hold counter: repeat press every REPEAT_TICKS after the first HOLD_TICKS,
      // suppressed on the edge where the release is being accepted.
      hc_d[i] = hc_q[i];
      if (!level_q[i]) begin
        hc_d[i] = '0;
      end else if (tick) begin
        if (hc_q[i] == HOLD_LAST) begin
          hc_d[i] = HOLD_RELOAD;
          if (level_d[i]) begin
            press_d[i] = 1'b1;
          end
        end else begin
          hc_d[i] = hc_q[i] + 1'b1;
        end
      end
`endif
    end
  end

  // State registers: synchronizers, prescaler, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      presc_q <= '0;
      level_q <= '0;
      press_q <= '0;
      rel_q   <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
`ifdef AUTOREPEAT_EN
        hc_q[i]  <= '0;
`endif
      end
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
      presc_q <= presc_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
`ifdef AUTOREPEAT_EN
        hc_q[i]  <= hc_d[i];
`endif
      end
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = rel_q;

endmodule

// File: tb/tb_multi_button_debounce.sv
// tb/tb_multi_button_debounce.sv - scoreboard bench for multi_button_debounce
module tb_multi_button_debounce;

  localparam int NCH = 3;
  localparam int TD  = 4;
  localparam int ST  = 3;
  localparam int HT  = 5;
  localparam int RT  = 2;
  localparam int LAT_MIN = (ST - 1) * TD + 3;
  localparam int LAT_MAX = ST * TD + 2;

  typedef struct {
    logic [NCH-1:0] press;
    logic [NCH-1:0] rel;
    logic [NCH-1:0] level;
    int             cyc;
  } ev_t;

  typedef struct {
    logic [NCH-1:0] press;
    logic [NCH-1:0] rel;
    logic [NCH-1:0] level;
    int             t0;
    int             lo;
    int             hi;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] btn_in;
  logic [NCH-1:0] btn_level;
  logic [NCH-1:0] btn_press;
  logic [NCH-1:0] btn_release;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  ev_t  obs_q[$];
  exp_t exp_q[$];
  ev_t  o;
  exp_t e;

  multi_button_debounce #(
    .NCH(NCH), .TICK_DIV(TD), .STABLE_TICKS(ST), .HOLD_TICKS(HT), .REPEAT_TICKS(RT)
  ) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe cycle becomes an observed event.
  always @(negedge clk) begin
    if (btn_press !== '0 || btn_release !== '0)
      obs_q.push_back('{btn_press, btn_release, btn_level, cyc});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #6;
  endtask

  task automatic wait_obs(input int budget);
    int n = 0;
    while (obs_q.size() == 0 && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    btn_in = '1;
    for (int k = 0; k < 6; k++) begin
      step();
      checks++;
      if ({btn_level, btn_press, btn_release} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: got level=%b press=%b release=%b required all 0",
                 btn_level, btn_press, btn_release);
      end
    end
    rst = 1'b0;
    exp_q.push_back('{3'b111, 3'b000, 3'b111, cyc, LAT_MIN, LAT_MAX});
    wait_obs(20);
    e = exp_q.pop_front();
    checks++;
    if (obs_q.size() == 0) begin
      errors++;
      $display("FAIL reset_requalify: got no strobe required press=%b", e.press);
    end else begin
      o = obs_q.pop_front();
      if ({o.press, o.rel, o.level} !== {e.press, e.rel, e.level}) begin
        errors++;
        $display("FAIL reset_requalify: got press=%b release=%b level=%b required press=%b release=%b level=%b",
                 o.press, o.rel, o.level, e.press, e.rel, e.level);
      end
      checks++;
      if (o.cyc - e.t0 < e.lo || o.cyc - e.t0 > e.hi) begin
        errors++;
        $display("FAIL reset_latency: got %0d clk required %0d..%0d", o.cyc - e.t0, e.lo, e.hi);
      end
    end
    for (int k = 0; k < 10; k++) step();
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL reset_extra: got %0d extra strobes required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_clean_press();
    rst    = 1'b1;
    btn_in = '0;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if ({btn_level, btn_press, btn_release} !== '0) begin
        errors++;
        $display("FAIL clear_reset: got level=%b press=%b release=%b required all 0",
                 btn_level, btn_press, btn_release);
      end
    end
    rst = 1'b0;
    for (int k = 0; k < 16; k++) step();
    checks++;
    if (obs_q.size() != 0 || btn_level !== '0) begin
      errors++;
      $display("FAIL clear_idle: got %0d strobes level=%b required 0 strobes level=000",
               obs_q.size(), btn_level);
      obs_q.delete();
    end
    for (int ph = 0; ph < 4; ph++) begin
      for (int k = 0; k < ph; k++) step();
      for (int dir = 1; dir >= 0; dir--) begin
        btn_in[0] = dir[0];
        if (dir == 1) exp_q.push_back('{3'b001, 3'b000, 3'b001, cyc, LAT_MIN, LAT_MAX});
        else          exp_q.push_back('{3'b000, 3'b001, 3'b000, cyc, LAT_MIN, LAT_MAX});
        wait_obs(20);
        e = exp_q.pop_front();
        checks++;
        if (obs_q.size() == 0) begin
          errors++;
          $display("FAIL clean_edge: phase %0d got no strobe required press=%b release=%b", ph, e.press, e.rel);
        end else begin
          o = obs_q.pop_front();
          if ({o.press, o.rel, o.level} !== {e.press, e.rel, e.level}) begin
            errors++;
            $display("FAIL clean_edge: phase %0d got press=%b release=%b level=%b required press=%b release=%b level=%b",
                     ph, o.press, o.rel, o.level, e.press, e.rel, e.level);
          end
          checks++;
          if (o.cyc - e.t0 < e.lo || o.cyc - e.t0 > e.hi) begin
            errors++;
            $display("FAIL clean_latency: phase %0d got %0d clk required %0d..%0d", ph, o.cyc - e.t0, e.lo, e.hi);
          end
        end
        step();
        checks++;
        if (btn_press !== '0 || btn_release !== '0) begin
          errors++;
          $display("FAIL strobe_width: got press=%b release=%b required 000 one clk later", btn_press, btn_release);
        end
      end
    end
  endtask

  task automatic test_bounce();
    for (int k = 0; k < 10; k++) begin
      btn_in[1] = ~k[0];
      for (int j = 0; j < 3; j++) step();
    end
    checks++;
    if (obs_q.size() != 0 || btn_level !== 3'b000) begin
      errors++;
      $display("FAIL bounce_quiet: got %0d strobes level=%b required 0 strobes level=000", obs_q.size(), btn_level);
      obs_q.delete();
    end
    btn_in[1] = 1'b1;
    exp_q.push_back('{3'b010, 3'b000, 3'b010, cyc, LAT_MIN, LAT_MAX});
    wait_obs(20);
    e = exp_q.pop_front();
    checks++;
    if (obs_q.size() == 0) begin
      errors++;
      $display("FAIL bounce_press: got no strobe required press=%b", e.press);
    end else begin
      o = obs_q.pop_front();
      if ({o.press, o.rel, o.level} !== {e.press, e.rel, e.level}) begin
        errors++;
        $display("FAIL bounce_press: got press=%b release=%b level=%b required press=%b release=%b level=%b",
                 o.press, o.rel, o.level, e.press, e.rel, e.level);
      end
      checks++;
      if (o.cyc - e.t0 < e.lo || o.cyc - e.t0 > e.hi) begin
        errors++;
        $display("FAIL bounce_latency: got %0d clk required %0d..%0d", o.cyc - e.t0, e.lo, e.hi);
      end
    end
    for (int k = 0; k < 20; k++) step();
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL bounce_single: got %0d extra strobes required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_simultaneous();
    btn_in[0] = 1'b1;
    exp_q.push_back('{3'b001, 3'b000, 3'b011, cyc, LAT_MIN, LAT_MAX});
    wait_obs(20);
    step();
    btn_in[0] = 1'b0;
    btn_in[2] = 1'b1;
    exp_q.push_back('{3'b100, 3'b001, 3'b110, cyc, LAT_MIN, LAT_MAX});
    wait_obs(20);
    for (int k = 0; k < 20; k++) step();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL simultaneous: got no strobe required press=%b release=%b", e.press, e.rel);
      end else begin
        o = obs_q.pop_front();
        if ({o.press, o.rel, o.level} !== {e.press, e.rel, e.level}) begin
          errors++;
          $display("FAIL simultaneous: got press=%b release=%b level=%b required press=%b release=%b level=%b",
                   o.press, o.rel, o.level, e.press, e.rel, e.level);
        end
        checks++;
        if (o.cyc - e.t0 < e.lo || o.cyc - e.t0 > e.hi) begin
          errors++;
          $display("FAIL simultaneous_latency: got %0d clk required %0d..%0d", o.cyc - e.t0, e.lo, e.hi);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL simultaneous_extra: got %0d extra strobes required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_rst_mid();
    rst    = 1'b1;
    btn_in = '0;
    for (int k = 0; k < 2; k++) step();
    obs_q.delete();
    rst       = 1'b0;
    btn_in[1] = 1'b1;
    for (int k = 0; k < 8; k++) step();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({btn_level, btn_press, btn_release} !== '0) begin
        errors++;
        $display("FAIL rst_mid_outputs: got level=%b press=%b release=%b required all 0",
                 btn_level, btn_press, btn_release);
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL rst_mid_strobe: got %0d strobes required 0", obs_q.size());
      obs_q.delete();
    end
    rst = 1'b0;
    exp_q.push_back('{3'b010, 3'b000, 3'b010, cyc, LAT_MIN, LAT_MAX});
    wait_obs(20);
    e = exp_q.pop_front();
    checks++;
    if (obs_q.size() == 0) begin
      errors++;
      $display("FAIL rst_mid_press: got no strobe required press=%b", e.press);
    end else begin
      o = obs_q.pop_front();
      if ({o.press, o.rel, o.level} !== {e.press, e.rel, e.level}) begin
        errors++;
        $display("FAIL rst_mid_press: got press=%b release=%b level=%b required press=%b release=%b level=%b",
                 o.press, o.rel, o.level, e.press, e.rel, e.level);
      end
      checks++;
      if (o.cyc - e.t0 < e.lo || o.cyc - e.t0 > e.hi) begin
        errors++;
        $display("FAIL rst_mid_latency: got %0d clk required %0d..%0d", o.cyc - e.t0, e.lo, e.hi);
      end
    end
  endtask

`ifdef AUTOREPEAT_EN
  task automatic test_autorepeat();
    int prev;
    rst    = 1'b1;
    btn_in = '0;
    for (int k = 0; k < 2; k++) step();
    obs_q.delete();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) step();
    btn_in[0] = 1'b1;
    // Initial press, repeats after HT ticks then every RT ticks, one more repeat
    // before the release is accepted.
    exp_q.push_back('{3'b001, 3'b000, 3'b001, cyc, LAT_MIN, LAT_MAX});
    exp_q.push_back('{3'b001, 3'b000, 3'b001, 0, HT * TD, HT * TD});
    exp_q.push_back('{3'b001, 3'b000, 3'b001, 0, RT * TD, RT * TD});
    exp_q.push_back('{3'b001, 3'b000, 3'b001, 0, RT * TD, RT * TD});
    exp_q.push_back('{3'b001, 3'b000, 3'b001, 0, RT * TD, RT * TD});
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      e = exp_q.pop_front();
      if (k > 0) e.t0 = prev;
      wait_obs(30);
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL autorepeat: strobe %0d got none required press=%b", k, e.press);
      end else begin
        o = obs_q.pop_front();
        prev = o.cyc;
        if ({o.press, o.rel, o.level} !== {e.press, e.rel, e.level}) begin
          errors++;
          $display("FAIL autorepeat: strobe %0d got press=%b release=%b level=%b required press=%b release=%b level=%b",
                   k, o.press, o.rel, o.level, e.press, e.rel, e.level);
        end
        checks++;
        if (o.cyc - e.t0 < e.lo || o.cyc - e.t0 > e.hi) begin
          errors++;
          $display("FAIL autorepeat_gap: strobe %0d got %0d clk required %0d..%0d", k, o.cyc - e.t0, e.lo, e.hi);
        end
      end
      if (k == 3) begin
        btn_in[0] = 1'b0;
        exp_q.push_back('{3'b000, 3'b001, 3'b000, cyc, LAT_MIN, LAT_MAX});
      end
    end
    e = exp_q.pop_front();
    wait_obs(20);
    checks++;
    if (obs_q.size() == 0) begin
      errors++;
      $display("FAIL autorepeat_release: got no strobe required release=%b", e.rel);
    end else begin
      o = obs_q.pop_front();
      if ({o.press, o.rel, o.level} !== {e.press, e.rel, e.level}) begin
        errors++;
        $display("FAIL autorepeat_release: got press=%b release=%b level=%b required press=%b release=%b level=%b",
                 o.press, o.rel, o.level, e.press, e.rel, e.level);
      end
      checks++;
      if (o.cyc - e.t0 < e.lo || o.cyc - e.t0 > e.hi) begin
        errors++;
        $display("FAIL autorepeat_release_latency: got %0d clk required %0d..%0d", o.cyc - e.t0, e.lo, e.hi);
      end
    end
    for (int k = 0; k < 40; k++) step();
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL autorepeat_stop: got %0d strobes after release required 0", obs_q.size());
      obs_q.delete();
    end
  endtask
`endif

  initial begin
    rst    = 1'b1;
    btn_in = '1;
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_rst_mid();
`ifdef AUTOREPEAT_EN
    test_autorepeat();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
